// File: rtl/aes_pipe_sched_if.sv
// ============================================================================
// aes_pipe_sched_if : requester, cipher and result-side signals of the AES scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

interface aes_pipe_sched_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_data;
  logic [127:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_data;
  logic [127:0] req1_key;
  logic [127:0] cph_datain;
  logic [127:0] cph_key;
  logic [127:0] cph_dataout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_id;
  logic         busy;

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    output cph_dataout, out_ready,
    input  req0_ready, req1_ready, cph_datain, cph_key,
    input  out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    input  cph_dataout, out_ready,
    output req0_ready, req1_ready, cph_datain, cph_key,
    output out_valid, out_data, out_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/aes_pipe_sched.sv
// ============================================================================
// aes_pipe_sched : two-requester scheduler and credit controller for a stall-free
// AES-128 pipeline. Define AES_SCHED_RR_EN for round-robin, else fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_pipe_sched #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  aes_pipe_sched_if.slave bus
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int TAGS = LATENCY + 1;

  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_fcnt;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [127:0]          r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_id;
  logic [TAGS-1:0]       r_tag_v;
  logic [TAGS-1:0]       r_tag_id;
  logic [127:0]          r_cph_data;
  logic [127:0]          r_cph_key;

  logic w_can, w_gnt0, w_gnt1, w_acc, w_pop, w_wr, w_ov;

  // Credits cover in-flight blocks plus FIFO occupancy, so a result can never
  // arrive at a full FIFO; a pop only frees a credit from the next cycle on.
  assign w_can = !rst && (r_cnt < CW'(FIFO_DEPTH));

`ifdef AES_SCHED_RR_EN
  logic r_ptr;

  assign w_gnt0 = w_can && bus.req0_valid && (!bus.req1_valid || !r_ptr);
  assign w_gnt1 = w_can && bus.req1_valid && (!bus.req0_valid ||  r_ptr);

  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= 1'b0;
    else if (w_acc) r_ptr <= w_gnt0;
  end
`else
  assign w_gnt0 = w_can && bus.req0_valid;
  assign w_gnt1 = w_can && bus.req1_valid && !bus.req0_valid;
`endif

  assign w_acc = w_gnt0 || w_gnt1;
  assign w_ov  = (r_fcnt != '0);
  assign w_pop = w_ov && bus.out_ready;
  assign w_wr  = r_tag_v[TAGS-1];

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.cph_datain = r_cph_data;
  assign bus.cph_key    = r_cph_key;
  assign bus.out_valid  = w_ov;
  assign bus.out_data   = w_ov ? r_mem[r_rptr] : '0;
  assign bus.out_id     = w_ov ? r_mem_id[r_rptr] : 1'b0;
  assign bus.busy       = (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cph_data <= '0;
      r_cph_key  <= '0;
    end else if (w_acc) begin
      r_cph_data <= w_gnt1 ? bus.req1_data : bus.req0_data;
      r_cph_key  <= w_gnt1 ? bus.req1_key  : bus.req0_key;
    end
  end

  // Tag line runs one stage longer than the cipher: the exiting tag lines up
  // with the ciphertext already settled on cph_dataout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[TAGS-2:0], w_acc};
      r_tag_id <= {r_tag_id[TAGS-2:0], w_gnt1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_wr)  r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop) r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr]    <= bus.cph_dataout;
      r_mem_id[r_wptr] <= r_tag_id[TAGS-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_wr && (r_fcnt == CW'(FIFO_DEPTH))));

endmodule

`default_nettype wire

// File: tb/tb_aes_pipe_sched.sv
// Directed bench for aes_pipe_sched with a stand-in cipher pipeline; outputs are
// scoreboarded against accepted blocks in accept order.
`default_nettype none

module tb_aes_pipe_sched;
  localparam int LATENCY    = 10;
  localparam int FIFO_DEPTH = 16;
`ifdef AES_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  aes_pipe_sched_if bus_if ();

  aes_pipe_sched #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: FIPS-197 vector answered exactly, anything else scrambled.
  function automatic logic [127:0] cipher_f(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {d[63:0], d[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  logic [127:0] cpipe [LATENCY];
  always @(posedge clk) begin
    cpipe[0] <= cipher_f(bus_if.cph_datain, bus_if.cph_key);
    for (int i = 1; i < LATENCY; i++) cpipe[i] <= cpipe[i-1];
  end
  assign bus_if.cph_dataout = cpipe[LATENCY-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [128:0] exp_q [$];
  int           acc_ids [$];
  int           pop_cyc [$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus_if.out_valid && bus_if.out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL out_unexpected: observed data %h expected no output", bus_if.out_data);
        end else begin
          logic [128:0] e;
          e = exp_q.pop_front();
          check("out_data", bus_if.out_data, e[127:0]);
          check("out_id", bus_if.out_id, e[128]);
        end
      end
      if (bus_if.req0_valid && bus_if.req0_ready) begin
        exp_q.push_back({1'b0, cipher_f(bus_if.req0_data, bus_if.req0_key)});
        acc_ids.push_back(0);
      end
      if (bus_if.req1_valid && bus_if.req1_ready) begin
        exp_q.push_back({1'b1, cipher_f(bus_if.req1_data, bus_if.req1_key)});
        acc_ids.push_back(1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus_if.busy && n < 100) begin step(); n++; end
    check(tag, bus_if.busy, 1'b0);
  endtask

  initial begin
    int lat;
    int a0;
    rst = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    bus_if.req0_data  = '0;
    bus_if.req0_key   = '0;
    bus_if.req1_data  = '0;
    bus_if.req1_key   = '0;
    bus_if.out_ready  = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_ready0", bus_if.req0_ready, 1'b0);
    check("rst_ready1", bus_if.req1_ready, 1'b0);
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_out_data", bus_if.out_data, 128'h0);
    check("rst_out_id", bus_if.out_id, 1'b0);
    check("rst_cph_datain", bus_if.cph_datain, 128'h0);
    check("rst_cph_key", bus_if.cph_key, 128'h0);

    // FIPS-197 block on req0 with open output
    step();
    rst = 1'b0;
    bus_if.req1_valid = 1'b0;
    bus_if.out_ready  = 1'b1;
    bus_if.req0_data  = FIPS_PT;
    bus_if.req0_key   = FIPS_KEY;
    @(negedge clk);
    check("fips_ready0", bus_if.req0_ready, 1'b1);
    check("fips_ready1", bus_if.req1_ready, 1'b0);
    step();
    bus_if.req0_valid = 1'b0;
    check("fips_cph_datain", bus_if.cph_datain, FIPS_PT);
    check("fips_cph_key", bus_if.cph_key, FIPS_KEY);
    check("fips_busy", bus_if.busy, 1'b1);
    lat = 0;
    while (!bus_if.out_valid && lat < 40) begin step(); lat++; end
    check("fips_latency", lat, LATENCY + 1);
    check("fips_data", bus_if.out_data, FIPS_CT);
    check("fips_id", bus_if.out_id, 1'b0);
    step();
    check("fips_busy_after", bus_if.busy, 1'b0);

    // Both requesters valid for 20 cycles, then req0 drops
    a0 = acc_ids.size();
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      bus_if.req0_valid = 1'b1;
      bus_if.req1_valid = 1'b1;
      bus_if.req0_data  = {32'h1000_0000, 64'h0, 32'(i)};
      bus_if.req0_key   = {96'h0, 32'(i * 7)};
      bus_if.req1_data  = {32'h2000_0000, 64'h0, 32'(i)};
      bus_if.req1_key   = {32'hffff_0000, 64'h0, 32'(i * 3)};
      step();
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_data  = 128'hdead_beef;
    @(negedge clk);
    check("drop_ready1", bus_if.req1_ready, 1'b1);
    step();
    bus_if.req1_valid = 1'b0;
    check("dual_accepts", acc_ids.size() - a0, 21);
    for (int j = 0; j < 20; j++)
      check("dual_grant_id", acc_ids[a0 + j], RR ? ((j + 1) % 2) : 0);
    check("drop_grant_id", acc_ids[a0 + 20], 1);
    wait_idle("dual_drain");
    check("dual_pops", pop_cyc.size(), 21);
    check("dual_back_to_back", pop_cyc[pop_cyc.size() - 1] - pop_cyc[0], 20);

    // Backpressure: fill all credits, then release one pop at a time
    bus_if.out_ready  = 1'b0;
    bus_if.req0_valid = 1'b1;
    a0 = acc_ids.size();
    for (int i = 0; i < 30; i++) begin
      bus_if.req0_data = {32'h3000_0000, 64'h0, 32'(i)};
      step();
    end
    check("bp_accepts", acc_ids.size() - a0, FIFO_DEPTH);
    @(negedge clk);
    check("bp_ready0_full", bus_if.req0_ready, 1'b0);
    check("bp_busy", bus_if.busy, 1'b1);
    check("bp_out_valid", bus_if.out_valid, 1'b1);
    step();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("bp_no_comb_credit", bus_if.req0_ready, 1'b0);
    step();
    @(negedge clk);
    check("bp_credit_freed", bus_if.req0_ready, 1'b1);
    step();
    @(negedge clk);
    check("bp_simul_pop_accept", bus_if.req0_ready, 1'b1);
    step();
    bus_if.req0_valid = 1'b0;
    wait_idle("bp_drain");
    check("bp_sb_empty", exp_q.size(), 0);

    // Reset with five blocks in flight
    for (int i = 0; i < 5; i++) begin
      bus_if.req0_valid = 1'b1;
      bus_if.req0_data  = {32'h4000_0000, 64'h0, 32'(i)};
      step();
    end
    bus_if.req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_data  = 128'h5555_0000_aaaa_1111_2222_3333_4444_6666;
    @(negedge clk);
    check("rst_mid_busy", bus_if.busy, 1'b0);
    check("rst_mid_out_valid", bus_if.out_valid, 1'b0);
    check("rst_mid_ready0", bus_if.req0_ready, 1'b1);
    step();
    bus_if.req0_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 40) begin step(); lat++; end
    check("rst_new_latency", lat, LATENCY + 1);
    step();
    wait_idle("rst_drain");
    check("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
